// File: rtl/wishbone_responder_model_if.sv
// Wishbone classic-cycle signal bundle between a core master and the responder model.
// master drives request fields; slave returns the ack/err termination and read data.
interface wishbone_responder_model_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_w;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_dat_r;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
    input  wb_ack, wb_err, wb_dat_r
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
    output wb_ack, wb_err, wb_dat_r
  );
endinterface

// File: rtl/wishbone_responder_model.sv
// Behavioural Wishbone classic slave: word memory with byte-lane writes, err on bad address.
// Response one cycle after WAIT_CYCLES waits; no new request sampled until the IDLE after RESP.
module wishbone_responder_model #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  wishbone_responder_model_if.slave        bus,
  output logic [31:0]                      ack_count,
  output logic [31:0]                      err_count
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_w_q, dat_w_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_r_q, dat_r_d;
  logic [31:0] ack_count_q, ack_count_d;
  logic [31:0] err_count_q, err_count_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  // Request fields seen by the responder: live bus in IDLE (zero-wait path), captured copy otherwise.
  logic        req_we;
  logic [31:0] req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat_w;
  logic [31:0] req_off;
  logic        req_bad;
  logic [AW-1:0] req_idx;
  logic        resp_go;
  logic        mem_wr_en;

  always_comb begin
    req_we    = we_q;
    req_adr   = adr_q;
    req_sel   = sel_q;
    req_dat_w = dat_w_q;
    if (state_q == ST_IDLE) begin
      req_we    = bus.wb_we;
      req_adr   = bus.wb_adr;
      req_sel   = bus.wb_sel;
      req_dat_w = bus.wb_dat_w;
    end
    req_off = req_adr - BASE_ADDR;
    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    req_bad = (req_adr[1:0] != 2'b00) || ((req_off >> 2) >= DEPTH_WORDS);
    req_idx = req_off[AW+1:2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_w_d     = dat_w_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_r_d     = '0;
    ack_count_d = ack_count_q;
    err_count_d = err_count_q;
    resp_go     = 1'b0;
    mem_wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.wb_cyc && bus.wb_stb) begin
          we_d    = bus.wb_we;
          adr_d   = bus.wb_adr;
          sel_d   = bus.wb_sel;
          dat_w_d = bus.wb_dat_w;
          cnt_d   = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            resp_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.wb_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (resp_go) begin
      if (req_bad) begin
        err_d       = 1'b1;
        err_count_d = err_count_q + 32'd1;
      end else begin
        ack_d       = 1'b1;
        ack_count_d = ack_count_q + 32'd1;
        if (req_we) begin
          mem_wr_en = 1'b1;
        end else begin
          dat_r_d = mem_q[req_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_w_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_r_q     <= '0;
      ack_count_q <= '0;
      err_count_q <= '0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_w_q     <= dat_w_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_r_q     <= dat_r_d;
      ack_count_q <= ack_count_d;
      err_count_q <= err_count_d;
      if (mem_wr_en) begin
        for (int i = 0; i < 4; i++) begin
          if (req_sel[i]) begin
            mem_q[req_idx][8*i +: 8] <= req_dat_w[8*i +: 8];
          end
        end
      end
    end
  end

  assign bus.wb_ack   = ack_q;
  assign bus.wb_err   = err_q;
  assign bus.wb_dat_r = dat_r_q;
  assign ack_count    = ack_count_q;
  assign err_count    = err_count_q;

  a_one_termination: assert property (@(posedge clk) disable iff (rst) !(ack_q && err_q));
  a_resp_matches_term: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_RESP) == (ack_q || err_q));
  a_dat_only_on_ack: assert property (@(posedge clk) disable iff (rst) (dat_r_q != '0) |-> ack_q);

endmodule

// File: tb/tb_wishbone_responder_model.sv
// Random and directed Wishbone traffic against two responders (2 and 0 wait states),
// checked by a queue scoreboard fed from an address-range/byte-lane reference model.
module tb_wishbone_responder_model;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          W2    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  wishbone_responder_model_if bus2();
  wishbone_responder_model_if bus0();
  logic [31:0] ackc2, errc2, ackc0, errc0;

  wishbone_responder_model #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .ack_count(ackc2), .err_count(errc2));

  wishbone_responder_model #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .ack_count(ackc0), .err_count(errc0));

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
    int          cyc;
    logic [31:0] ackc;
    logic [31:0] errc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  // Reference model: sparse memory keyed by (dut, word), plus per-dut event counts.
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_ack [2];
  logic [31:0] m_err [2];

  function automatic exp_t model(int d, bit we, logic [31:0] adr, logic [3:0] sel,
                                 logic [31:0] dat, int at);
    exp_t        e;
    longint      a  = longint'(adr);
    longint      lo = longint'(BASE);
    longint      hi = longint'(BASE) + 4 * DEPTH;
    int unsigned key;
    logic [31:0] w;
    e.cyc = at;
    e.dat = '0;
    if ((a % 4) != 0 || a < lo || a >= hi) begin
      e.is_err = 1'b1;
      m_err[d] = m_err[d] + 1;
    end else begin
      e.is_err = 1'b0;
      m_ack[d] = m_ack[d] + 1;
      key = (d << 16) | int'((a - lo) / 4);
      w = m_mem.exists(key) ? m_mem[key] : 32'h0;
      if (we) begin
        for (int i = 0; i < 4; i++) if (sel[i]) w[8*i +: 8] = dat[8*i +: 8];
        m_mem[key] = w;
      end else begin
        e.dat = w;
      end
    end
    e.ackc = m_ack[d];
    e.errc = m_err[d];
    return e;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  task automatic fail_now(string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc_n);
  endtask

  task automatic check_resp(string tag, exp_t e, logic ack, logic err, logic [31:0] dat,
                            logic [31:0] ac, logic [31:0] ec);
    cmp({tag, " err"}, {31'b0, err}, {31'b0, e.is_err});
    cmp({tag, " ack"}, {31'b0, ack}, {31'b0, !e.is_err});
    cmp({tag, " dat_r"}, dat, e.dat);
    cmp({tag, " resp cycle"}, cyc_n, e.cyc);
    cmp({tag, " ack_count"}, ac, e.ackc);
    cmp({tag, " err_count"}, ec, e.errc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus2.wb_ack || bus2.wb_err) begin
        if (q2.size() == 0) fail_now("w2 unexpected response");
        else check_resp("w2", q2.pop_front(), bus2.wb_ack, bus2.wb_err, bus2.wb_dat_r, ackc2, errc2);
      end else begin
        cmp("w2 idle dat_r", bus2.wb_dat_r, 32'h0);
      end
      if (bus0.wb_ack || bus0.wb_err) begin
        if (q0.size() == 0) fail_now("w0 unexpected response");
        else check_resp("w0", q0.pop_front(), bus0.wb_ack, bus0.wb_err, bus0.wb_dat_r, ackc0, errc0);
      end else begin
        cmp("w0 idle dat_r", bus0.wb_dat_r, 32'h0);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive2(bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    bus2.wb_cyc = 1'b1; bus2.wb_stb = 1'b1; bus2.wb_we = we;
    bus2.wb_adr = adr;  bus2.wb_sel = sel;  bus2.wb_dat_w = dat;
  endtask

  task automatic release2();
    bus2.wb_cyc = 1'b0; bus2.wb_stb = 1'b0; bus2.wb_we = 1'b0;
    bus2.wb_adr = $urandom; bus2.wb_sel = 4'($urandom); bus2.wb_dat_w = $urandom;
  endtask

  // Full classic cycle on the 2-wait responder; caller is 1 time unit after a rising edge.
  task automatic req2(bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    bit got = 1'b0;
    q2.push_back(model(0, we, adr, sel, dat, cyc_n + 1 + W2));
    drive2(we, adr, sel, dat);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus2.wb_ack || bus2.wb_err) got = 1'b1;
    end
    if (!got) fail_now("w2 response timeout");
    idle(1);
    release2();
  endtask

  // Zero-wait responder with stb held four cycles: captures at the first and third edges.
  task automatic hold0(bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    int c = cyc_n;
    q0.push_back(model(1, we, adr, sel, dat, c + 1));
    q0.push_back(model(1, we, adr, sel, dat, c + 3));
    bus0.wb_cyc = 1'b1; bus0.wb_stb = 1'b1; bus0.wb_we = we;
    bus0.wb_adr = adr;  bus0.wb_sel = sel;  bus0.wb_dat_w = dat;
    idle(4);
    bus0.wb_cyc = 1'b0; bus0.wb_stb = 1'b0; bus0.wb_we = 1'b0;
    idle(2);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 5) return BASE + 4 * $urandom_range(0, 15);
    if (r < 7) return BASE + 4 * $urandom_range(DEPTH - 4, DEPTH - 1);
    if (r == 7) return BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
    if (r == 8) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 8);
    return BASE - 4 * $urandom_range(1, 8);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired (cycle %0d)", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    m_ack[0] = 0; m_ack[1] = 0; m_err[0] = 0; m_err[1] = 0;
    release2();
    bus0.wb_cyc = 1'b0; bus0.wb_stb = 1'b0; bus0.wb_we = 1'b0;
    bus0.wb_adr = '0;   bus0.wb_sel = '0;   bus0.wb_dat_w = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    mon_en = 1'b1;

    cmp("reset ack_count", ackc2, 32'h0);
    cmp("reset err_count", errc2, 32'h0);
    cmp("reset wb_ack", {31'b0, bus2.wb_ack}, 32'h0);
    cmp("reset wb_err", {31'b0, bus2.wb_err}, 32'h0);

    req2(1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    req2(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    req2(1'b1, 32'h8000_0010, 4'b0101, 32'h1122_3344);
    req2(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    req2(1'b0, 32'h8000_1000, 4'hF, 32'h0);
    req2(1'b0, 32'h7FFF_FFFC, 4'hF, 32'h0);
    req2(1'b0, 32'h8000_0002, 4'hF, 32'h0);
    req2(1'b1, 32'h8000_0FFC, 4'hF, 32'hA5A5_0FFC);
    req2(1'b0, 32'h8000_0FFC, 4'h0, 32'h0);
    req2(1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF);
    req2(1'b0, 32'h8000_0010, 4'hF, 32'h0);

    // Abort: cyc drops in the first wait cycle, so nothing is written or counted.
    drive2(1'b1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D);
    idle(1);
    release2();
    idle(6);
    cmp("abort ack_count", ackc2, m_ack[0]);
    cmp("abort err_count", errc2, m_err[0]);
    req2(1'b0, 32'h8000_0010, 4'hF, 32'h0);

    for (int n = 0; n < 80; n++) begin
      a = rand_addr();
      req2(1'($urandom), a, 4'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) req2(1'b0, a, 4'hF, 32'h0);
      idle($urandom_range(0, 2));
    end

    // Reset while a write sits in its wait cycles: request dropped, all state cleared.
    req2(1'b1, 32'h8000_0020, 4'hF, 32'h1234_5678);
    drive2(1'b1, 32'h8000_0020, 4'hF, 32'h55AA_55AA);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    release2();
    m_mem.delete();
    m_ack[0] = 0; m_ack[1] = 0; m_err[0] = 0; m_err[1] = 0;
    cmp("post-reset ack_count", ackc2, 32'h0);
    cmp("post-reset err_count", errc2, 32'h0);
    cmp("post-reset wb_ack", {31'b0, bus2.wb_ack}, 32'h0);
    cmp("post-reset wb_dat_r", bus2.wb_dat_r, 32'h0);
    idle(5);
    req2(1'b0, 32'h8000_0020, 4'hF, 32'h0);

    hold0(1'b0, 32'h8000_0040, 4'hF, 32'h0);
    hold0(1'b1, 32'h8000_0040, 4'b1010, 32'h9876_5432);
    hold0(1'b0, 32'h8000_0040, 4'hF, 32'h0);
    hold0(1'b0, 32'h8000_0041, 4'hF, 32'h0);

    for (int k = 0; k < 50 && (q2.size() != 0 || q0.size() != 0); k++) idle(1);
    cmp("w2 responses outstanding", q2.size(), 32'h0);
    cmp("w0 responses outstanding", q0.size(), 32'h0);
    cmp("final w2 ack_count", ackc2, m_ack[0]);
    cmp("final w2 err_count", errc2, m_err[0]);
    cmp("final w0 ack_count", ackc0, m_ack[1]);
    cmp("final w0 err_count", errc0, m_err[1]);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
